// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the decode-stage hazard controller.
//   slot_t     : one scoreboard entry {v, rd, ld} for an in-flight register write
//   state_t    : HALT drain FSM encoding (RUN, DRAIN, HALTED)
//   PIPE_SLOTS : number of tracked stages (DX, XM, MW)
// The slot register field is sized for the widest supported select (8 bits);
// narrower selects are zero-extended on the way in, so REG_W <= 8.
package hazard_pkg;

   localparam int PIPE_SLOTS = 3;
   localparam int SLOT_REG_W = 8;

   typedef struct packed {
      logic                  v;
      logic [SLOT_REG_W-1:0] rd;
      logic                  ld;
   } slot_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/hazard_slot_cmp.sv
// hazard_slot_cmp: compares one scoreboard slot against both decode sources.
// Ports:
//   slot     in  scoreboard entry
//   rs1/rs2  in  source register selects
//   r1_used  in  source 1 is read
//   r2_used  in  source 2 is read
//   ld_only  in  1 = only a load in this slot counts as a hit
//   hit      out a read source matches this slot
module hazard_slot_cmp
   import hazard_pkg::*;
#(
   parameter int REG_W = 3
) (
   input  slot_t            slot,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             r1_used,
   input  logic             r2_used,
   input  logic             ld_only,
   output logic             hit
);

   logic s1_match;
   logic s2_match;

   assign s1_match = r1_used & slot.v & (slot.rd == SLOT_REG_W'(rs1));
   assign s2_match = r2_used & slot.v & (slot.rd == SLOT_REG_W'(rs2));
   assign hit      = (s1_match | s2_match) & (~ld_only | slot.ld);

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard / stall controller ahead of ID/EX.
// Tracks in-flight register writes in DX/XM/MW slots, stalls decode on RAW
// hazards, bubbles on taken-branch flush, and drains the pipe on HALT.
// Ports:
//   clk, rst              clock, async active-low reset
//   id_*                  decode instruction fields
//   ex_flush              taken branch/jump in EX, kill decode
//   stall                 hold PC and IF/ID
//   bubble                zero control bits into ID/EX
//   dx_en                 ID/EX enable, always 1
//   halt_drained          HALT issued and all older slots retired
//   inflight              {MW, XM, DX} slot valid bits
// Build option: FORWARD_EN -- assume EX/MEM and MEM/WB forwarding, so only a
// load-use hit on DX stalls.
module id_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W     = 3,
   parameter bit RF_BYPASS = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_W-1:0]      id_readRegSel1,
   input  logic [REG_W-1:0]      id_readRegSel2,
   input  logic                  id_r1_hdu,
   input  logic                  id_r2_hdu,
   input  logic [REG_W-1:0]      id_writeRegSel,
   input  logic                  id_regWrite,
   input  logic                  id_memRead,
   input  logic                  id_HALT,
   input  logic                  ex_flush,
   output logic                  stall,
   output logic                  bubble,
   output logic                  dx_en,
   output logic                  halt_drained,
   output logic [PIPE_SLOTS-1:0] inflight
);

   // Slot order: [0]=DX, [1]=XM, [2]=MW. SLOT_MASK selects which slots can stall.
`ifdef FORWARD_EN
   localparam logic [PIPE_SLOTS-1:0] SLOT_MASK = 3'b001;
   localparam logic                  LD_ONLY   = 1'b1;
`else
   localparam logic [PIPE_SLOTS-1:0] SLOT_MASK = RF_BYPASS ? 3'b011 : 3'b111;
   localparam logic                  LD_ONLY   = 1'b0;
`endif
   // Last DRAIN count: the HALT leaves MW on the edge after this count.
   localparam logic [1:0] DRAIN_LAST = 2'(PIPE_SLOTS - 1);

   slot_t [PIPE_SLOTS-1:0] slots;
   logic  [PIPE_SLOTS-1:0] hit;
   state_t                 state;
   logic   [1:0]           drain_cnt;
   logic                   hazard;
   logic                   issue;

   for (genvar g = 0; g < PIPE_SLOTS; g++) begin : g_cmp
      hazard_slot_cmp #(.REG_W(REG_W)) u_cmp (
         .slot    (slots[g]),
         .rs1     (id_readRegSel1),
         .rs2     (id_readRegSel2),
         .r1_used (id_r1_hdu),
         .r2_used (id_r2_hdu),
         .ld_only (LD_ONLY),
         .hit     (hit[g])
      );
   end

   assign hazard       = id_valid & ~ex_flush & |(hit & SLOT_MASK);
   assign stall        = hazard | (state != RUN);
   // Held low during reset so ID/EX sees a clean state while rst is asserted.
   assign bubble       = rst & (stall | ex_flush | ~id_valid);
   assign issue        = id_valid & ~stall & ~ex_flush;
   assign dx_en        = 1'b1;
   assign halt_drained = (state == HALTED);
   assign inflight     = {slots[2].v, slots[1].v, slots[0].v};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slots     <= '0;
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         slots[2] <= slots[1];
         slots[1] <= slots[0];
         // The HALT itself rides DX as a non-writing (empty) slot.
         slots[0] <= (issue && id_regWrite)
                     ? {1'b1, SLOT_REG_W'(id_writeRegSel), id_memRead}
                     : '0;
         case (state)
            RUN: begin
               if (issue && id_HALT) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST && !slots[0].v && !slots[1].v)
                  state <= HALTED;
               else
                  drain_cnt <= drain_cnt + 2'd1;
            end
            HALTED:  ;
            default: state <= RUN;
         endcase
      end
   end

endmodule
